ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter:
//   ps2_state_e     - transmitter FSM states
//   FRAME_LEN       - bits shifted out after the start bit (8 data, parity, stop)
//   KEYBOARD_TX_AD  - MMIO address used by the bus wrapper for this block
//   odd_parity()    - parity bit that makes data+parity contain an odd count of ones
//   build_frame()   - {stop, parity, data[7:0]} as sent LSB first
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        REQ      = 3'd2,
        BITS     = 3'd3,
        ACK      = 3'd4,
        WAIT_REL = 3'd5
    } ps2_state_e;

    localparam int FRAME_LEN = 10;

    localparam logic [31:0] KEYBOARD_TX_AD = 32'h1124_0000;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings one raw open-drain PS/2 line into the CLK domain through two flops
// and flags its falling edges.
//   CLK       in   system clock
//   RST_N     in   synchronous active-low reset
//   line_raw  in   asynchronous line level
//   line_sync out  synchronized level
//   line_fall out  one-cycle pulse when the synchronized level goes 1 -> 0
// Every stage resets to 1 because an idle PS/2 line floats high; this keeps
// reset release from producing a false falling edge.
// ---------------------------------------------------------------------------
module ps2_line_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic line_raw,
    output logic line_sync,
    output logic line_fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= line_raw;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign line_sync = sync_r;
    assign line_fall = prev_r & ~sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device: inhibit the clock,
// issue the start bit, shift data/parity/stop on device clock falling edges,
// then capture the device acknowledge.
//   CLK         in   system clock (single domain)
//   RST_N       in   synchronous active-low reset
//   TX_DATA     in   [7:0] command byte
//   TX_START    in   one-cycle request, latches TX_DATA when idle
//   PS2CLK_IN   in   raw PS/2 clock line
//   PS2DATA_IN  in   raw PS/2 data line
//   PS2CLK_OE   out  1 = pull PS/2 clock low
//   PS2DATA_OE  out  1 = pull PS/2 data low
//   BUSY        out  transfer in progress
//   DONE        out  one-cycle pulse on normal completion
//   ACK_OK      out  device acknowledged the last completed transfer
//   ERR         out  one-cycle pulse when the transfer times out
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    input  logic       PS2CLK_IN,
    input  logic       PS2DATA_IN,
    output logic       PS2CLK_OE,
    output logic       PS2DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_OK,
    output logic       ERR
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'(FRAME_LEN - 1);

    ps2_state_e           state_r;
    logic [FRAME_LEN-1:0] frame_r;
    logic [3:0]           bit_idx_r;
    logic [INH_W-1:0]     inh_cnt_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic                 clk_oe_r;
    logic                 data_oe_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 ack_ok_r;
    logic                 err_r;

    logic clk_sync_s;
    logic clk_fall_s;
    logic data_sync_s;
    logic data_fall_unused_s;
    logic tmo_active_s;
    logic tmo_hit_s;

    ps2_line_sync u_clk_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .line_raw  (PS2CLK_IN),
        .line_sync (clk_sync_s),
        .line_fall (clk_fall_s)
    );

    // Data-line edges carry no meaning for the transmitter; only its level is used.
    ps2_line_sync u_data_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .line_raw  (PS2DATA_IN),
        .line_sync (data_sync_s),
        .line_fall (data_fall_unused_s)
    );

    // States in which the device is expected to make progress and may stall out.
    assign tmo_active_s = (state_r == REQ) || (state_r == BITS) ||
                          (state_r == ACK) || (state_r == WAIT_REL);

    // A device clock edge in the same cycle always wins over the timeout.
    assign tmo_hit_s = tmo_active_s && !clk_fall_s && (tmo_cnt_r == TMO_LAST);

    // Transmitter FSM with registered line drivers and status outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= IDLE;
            frame_r   <= {FRAME_LEN{1'b0}};
            bit_idx_r <= 4'd0;
            inh_cnt_r <= {INH_W{1'b0}};
            tmo_cnt_r <= {TMO_W{1'b0}};
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_ok_r  <= 1'b0;
            err_r     <= 1'b0;
        end else if (tmo_hit_s) begin
            state_r   <= IDLE;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_ok_r  <= 1'b0;
            err_r     <= 1'b1;
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;

            if (tmo_active_s) begin
                if (clk_fall_s) begin
                    tmo_cnt_r <= {TMO_W{1'b0}};
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end

            case (state_r)
                IDLE: begin
                    if (TX_START) begin
                        frame_r   <= build_frame(TX_DATA);
                        busy_r    <= 1'b1;
                        clk_oe_r  <= 1'b1;
                        data_oe_r <= 1'b0;
                        ack_ok_r  <= 1'b0;
                        inh_cnt_r <= {INH_W{1'b0}};
                        state_r   <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (inh_cnt_r == INH_LAST) begin
                        data_oe_r <= 1'b1;
                        tmo_cnt_r <= {TMO_W{1'b0}};
                        state_r   <= REQ;
                    end else begin
                        inh_cnt_r <= inh_cnt_r + {{(INH_W-1){1'b0}}, 1'b1};
                    end
                end

                // Start bit is on the line; hand the clock back to the device.
                REQ: begin
                    clk_oe_r  <= 1'b0;
                    bit_idx_r <= 4'd0;
                    state_r   <= BITS;
                end

                // Frame bit 9 is the stop bit (1), so its edge releases the data line.
                BITS: begin
                    if (clk_fall_s) begin
                        data_oe_r <= ~frame_r[bit_idx_r];
                        bit_idx_r <= bit_idx_r + 4'd1;
                        if (bit_idx_r == LAST_IDX) begin
                            state_r <= ACK;
                        end
                    end
                end

                // Device pulls data low during this clock edge to acknowledge.
                ACK: begin
                    if (clk_fall_s) begin
                        ack_ok_r <= ~data_sync_s;
                        state_r  <= WAIT_REL;
                    end
                end

                WAIT_REL: begin
                    if (clk_sync_s && data_sync_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign PS2CLK_OE  = clk_oe_r;
    assign PS2DATA_OE = data_oe_r;
    assign BUSY       = busy_r;
    assign DONE       = done_r;
    assign ACK_OK     = ack_ok_r;
    assign ERR        = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a PS/2 device model that clocks one falling edge
// every 40 CLK cycles and records the data line after each edge. Expected
// frames come from a reference that counts ones in the byte.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2clk_line;
    logic       ps2data_line;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    // open-drain wired-AND of host and device
    assign ps2clk_line  = ~(ps2clk_oe | dev_clk_low);
    assign ps2data_line = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .TX_DATA    (tx_data),
        .TX_START   (tx_start),
        .PS2CLK_IN  (ps2clk_line),
        .PS2DATA_IN (ps2data_line),
        .PS2CLK_OE  (ps2clk_oe),
        .PS2DATA_OE (ps2data_oe),
        .BUSY       (busy),
        .DONE       (done),
        .ACK_OK     (ack_ok),
        .ERR        (err)
    );

    // pulse bookkeeping for whole-run properties
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Line levels after edges 1..10: data LSB first, odd parity, stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic pulse_start(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Counts cycles with only the clock inhibited; leaves the bench on the
    // first negedge where the start bit is driven.
    task automatic measure_inhibit(output int n);
        n = 0;
        while (!ps2data_oe && n < 1000) begin
            if (ps2clk_oe) n++;
            @(negedge clk);
        end
    endtask

    task automatic dev_xfer(input int n_edges, input bit do_ack, input bit poke,
                            output logic start_lvl, output logic [9:0] bits, output bit ok);
        int w;
        ok = 1'b0;
        bits = 10'h000;
        start_lvl = 1'b1;
        w = 0;
        while (!(ps2clk_oe == 1'b0 && ps2data_oe == 1'b1) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) return;
        ok = 1'b1;
        start_lvl = ps2data_line;
        for (int e = 0; e < n_edges; e++) begin
            idle(20);
            dev_clk_low = 1'b1;
            idle(15);
            bits[e] = ps2data_line;
            idle(5);
            dev_clk_low = 1'b0;
            if (poke && e == 1) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                check_eq("busy_after_poke", busy, 1);
            end
        end
        if (n_edges == 10) begin
            idle(15);
            dev_data_low = do_ack;
            idle(5);
            dev_clk_low = 1'b1;
            idle(20);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, input bit poke);
        int n;
        int d0;
        int e0;
        logic start_lvl;
        logic [9:0] bits;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(b);
        check_eq("busy_rise", busy, 1);
        check_eq("clk_inhibit", ps2clk_oe, 1);
        measure_inhibit(n);
        check_eq("inhibit_len", n, INH);
        dev_xfer(10, ack, poke, start_lvl, bits, ok);
        check_eq("dev_req_seen", ok, 1);
        check_eq("start_bit", start_lvl, 0);
        check_eq("frame", bits, ref_frame(b));
        check_eq("busy_before_done", busy, 1);
        n = 0;
        while (!done && !err && n < 100) begin
            @(negedge clk);
            n++;
            if (!done) check_eq("busy_hold", busy, 1);
        end
        check_eq("done_pulse", done, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("ack_ok", ack_ok, ack);
        @(negedge clk);
        check_eq("done_width", done, 0);
        check_eq("ack_ok_hold", ack_ok, ack);
        idle(60);
        check_eq("done_count", done_cnt - d0, 1);
        check_eq("err_count", err_cnt - e0, 0);
        check_eq("idle_after", {busy, ps2clk_oe, ps2data_oe}, 0);
    endtask

    // bounded run time
    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int n;
        int d0;
        int e0;
        logic start_lvl;
        logic [9:0] bits;
        bit ok;
        logic [7:0] rb;
        bit rack;

        rst_n        = 1'b0;
        tx_data      = 8'h00;
        tx_start     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        idle(3);
        check_eq("reset_outputs", {ps2clk_oe, ps2data_oe, busy, done, ack_ok, err}, 0);
        rst_n = 1'b1;
        idle(5);

        // acknowledged 0xED
        run_xfer(8'hED, 1'b1, 1'b0);
        // device does not acknowledge 0xF4
        run_xfer(8'hF4, 1'b0, 1'b0);

        // no device clocks: timeout 200 cycles after the start bit
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'h5A);
        measure_inhibit(n);
        check_eq("tmo_inhibit_len", n, INH);
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("tmo_latency", n, TMO);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_lines", {ps2clk_oe, ps2data_oe}, 0);
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_ack_ok", ack_ok, 0);
        @(negedge clk);
        check_eq("tmo_err_width", err, 0);
        idle(50);
        check_eq("tmo_no_done", done_cnt - d0, 0);
        check_eq("tmo_err_count", err_cnt - e0, 1);

        // 0x00 with an ignored 0xFF request in mid-transfer
        run_xfer(8'h00, 1'b1, 1'b1);

        // reset after the fourth data edge
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'h3C);
        measure_inhibit(n);
        dev_xfer(4, 1'b1, 1'b0, start_lvl, bits, ok);
        check_eq("rst_dev_req", ok, 1);
        check_eq("rst_partial_bits", bits[3:0], ref_frame(8'h3C) & 10'h00F);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_mid_outputs", {ps2clk_oe, ps2data_oe, busy, done, ack_ok, err}, 0);
        idle(300);
        check_eq("rst_no_done", done_cnt - d0, 0);
        check_eq("rst_no_err", err_cnt - e0, 0);
        check_eq("rst_idle", {busy, ps2clk_oe, ps2data_oe}, 0);
        run_xfer(8'hED, 1'b1, 1'b0);

        // random bytes and acknowledge choices
        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            run_xfer(rb, rack, 1'b0);
        end

        check_eq("done_err_overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
